serial_word_receiver: RTL

//  Serial-in/parallel-out receiver. Counterpart of the universal shift-register chain,

---
 rtl/serial_pkg.sv | 15 +
 rtl/sipo_shift_core.sv | 36 +++
 rtl/serial_word_receiver.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared types and helpers for the serial word receiver slice.
// Receiver FSM encoding and the bit-counter sizing rule.
package serial_pkg;

  typedef logic [0:0] state_t;

  localparam state_t IDLE  = 1'b0;
  localparam state_t SHIFT = 1'b1;

  // Counter must be able to hold the value WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// WIDTH-bit serial-in shift register; exposes the post-shift value so the
// caller can capture a completed word on the same edge as its last bit.
module sipo_shift_core #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en,
  input  logic             load_bit,
  output logic [WIDTH-1:0] shift_next
);

  logic [WIDTH-1:0] shift_r;

  // Next shift value: MSB-first enters at bit 0, LSB-first enters at the top.
  always_comb begin
    if (MSB_FIRST) begin
      shift_next = {shift_r[WIDTH-2:0], load_bit};
    end else begin
      shift_next = {load_bit, shift_r[WIDTH-1:1]};
    end
  end

  // Shift register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_r <= {WIDTH{1'b0}};
    end else if (shift_en) begin
      shift_r <= shift_next;
    end else begin
      shift_r <= shift_r;
    end
  end

endmodule

// File: rtl/serial_word_receiver.sv
// Framed serial-to-parallel receiver with a one-word holding register,
// valid/ready output handshake and a sticky overrun flag.
module serial_word_receiver
  import serial_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             async_reset_n,
  input  logic             serial_in,
  input  logic             bit_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  input  logic             clear_overrun,
  output logic             busy
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] ZERO_CNT = CNT_W'(0);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] bit_cnt_r;
  logic [CNT_W-1:0] bit_cnt_nxt_s;
  logic             shift_en_s;
  logic             complete_s;
  logic             consume_s;
  logic             drop_s;
  logic [WIDTH-1:0] shift_next_s;
  logic [WIDTH-1:0] parallel_out_r;
  logic             out_valid_r;
  logic             overrun_r;
  logic             drop_pend_r;

  sipo_shift_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk        (clk),
    .rst_n      (async_reset_n),
    .shift_en   (shift_en_s),
    .load_bit   (serial_in),
    .shift_next (shift_next_s)
  );

  // Frame FSM and bit counter next-state; a restart never completes a word.
  always_comb begin
    state_nxt_s   = state_r;
    bit_cnt_nxt_s = bit_cnt_r;
    shift_en_s    = 1'b0;
    complete_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (bit_valid && frame_start) begin
          shift_en_s    = 1'b1;
          bit_cnt_nxt_s = ONE_CNT;
          state_nxt_s   = SHIFT;
        end else begin
          bit_cnt_nxt_s = bit_cnt_r;
          state_nxt_s   = IDLE;
        end
      end
      SHIFT: begin
        if (bit_valid && frame_start) begin
          shift_en_s    = 1'b1;
          bit_cnt_nxt_s = ONE_CNT;
          state_nxt_s   = SHIFT;
        end else if (bit_valid) begin
          shift_en_s = 1'b1;
          if (bit_cnt_r == LAST_CNT) begin
            complete_s    = 1'b1;
            bit_cnt_nxt_s = ZERO_CNT;
            state_nxt_s   = IDLE;
          end else begin
            bit_cnt_nxt_s = bit_cnt_r + ONE_CNT;
            state_nxt_s   = SHIFT;
          end
        end else begin
          bit_cnt_nxt_s = bit_cnt_r;
          state_nxt_s   = SHIFT;
        end
      end
      default: begin
        bit_cnt_nxt_s = ZERO_CNT;
        state_nxt_s   = IDLE;
      end
    endcase
  end

  assign consume_s = out_valid_r && out_ready;
  assign drop_s    = complete_s && out_valid_r && !out_ready;

  // FSM state and bit counter.
  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      state_r   <= IDLE;
      bit_cnt_r <= ZERO_CNT;
    end else begin
      state_r   <= state_nxt_s;
      bit_cnt_r <= bit_cnt_nxt_s;
    end
  end

  // Holding register: load on completion unless an unconsumed word blocks it.
  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      parallel_out_r <= {WIDTH{1'b0}};
      out_valid_r    <= 1'b0;
    end else if (complete_s && (!out_valid_r || out_ready)) begin
      parallel_out_r <= shift_next_s;
      out_valid_r    <= 1'b1;
    end else if (consume_s) begin
      parallel_out_r <= parallel_out_r;
      out_valid_r    <= 1'b0;
    end else begin
      parallel_out_r <= parallel_out_r;
      out_valid_r    <= out_valid_r;
    end
  end

  // A dropped word raises overrun one edge later; raising beats clearing.
  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      drop_pend_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      drop_pend_r <= drop_s;
      if (drop_pend_r) begin
        overrun_r <= 1'b1;
      end else if (clear_overrun) begin
        overrun_r <= 1'b0;
      end else begin
        overrun_r <= overrun_r;
      end
    end
  end

  assign parallel_out = parallel_out_r;
  assign out_valid    = out_valid_r;
  assign overrun      = overrun_r;
  assign busy         = (state_r == SHIFT);

endmodule
